// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, drives the synchronous
// instruction ROM, tracks the single in-flight read and registers the
// returned word into the IF/ID boundary. Handles stalls, delay-slot branch
// redirects from ID and exception flushes.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_if,
  input  logic        i_stall_id,
  input  logic        i_flush,
  input  logic [31:0] i_new_pc,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_target,
  output logic        o_rom_ce,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_data,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst,
  output logic        o_id_valid
);

  // Read issued to the ROM last cycle whose data is on i_rom_data now.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
  } inf_t;

  // IF/ID boundary register seen by decode.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{vld: 1'b0, pc: 32'h0, inst: NOP_INST};
  localparam inf_t  INF_RESET   = '{vld: 1'b0, pc: 32'h0};

  logic [31:0] r_pc;
  logic        r_ce;
  inf_t        r_inf;
  ifid_t       r_ifid;

  logic [31:0] w_pc_nxt;
  inf_t        w_inf_nxt;
  ifid_t       w_ifid_nxt;
  logic        w_stall;

  // A held IF/ID register must also freeze fetch, otherwise the word
  // returning from the ROM would have nowhere to go.
  assign w_stall = i_stall_if | i_stall_id;

  // While stalled, re-present the in-flight address so i_rom_data keeps the
  // same word; during reset show the reset PC regardless of the stall input.
  assign o_rom_addr = (w_stall && !i_rst) ? r_inf.pc : r_pc;
  assign o_rom_ce   = r_ce;
  assign o_id_valid = r_ifid.vld;
  assign o_id_pc    = r_ifid.pc;
  assign o_id_inst  = r_ifid.inst;

  // Next PC: flush beats everything, nothing advances before the ROM is
  // enabled, a stall holds, a branch redirects, otherwise sequential (wraps).
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_flush)            w_pc_nxt = i_new_pc;
    else if (!r_ce)         w_pc_nxt = r_pc;
    else if (w_stall)       w_pc_nxt = r_pc;
    else if (i_branch_flag) w_pc_nxt = i_branch_target;
    else                    w_pc_nxt = r_pc + 32'd4;
  end

  // In-flight slot: the address issued this cycle becomes the outstanding
  // read, except when a branch squashes it (branch+8, past the delay slot).
  always_comb begin
    w_inf_nxt = r_inf;
    if (i_flush) begin
      w_inf_nxt.vld = 1'b0;
    end else if (!w_stall) begin
      w_inf_nxt.vld = r_ce & ~i_branch_flag;
      w_inf_nxt.pc  = r_pc;
    end
  end

  // IF/ID: hold while decode is stalled, bubble when only fetch is stalled
  // (decode drained its instruction), else capture the returning ROM word.
  always_comb begin
    w_ifid_nxt = r_ifid;
    if (i_flush) begin
      w_ifid_nxt = IFID_BUBBLE;
    end else if (w_stall) begin
      if (!i_stall_id) w_ifid_nxt = IFID_BUBBLE;
    end else begin
      w_ifid_nxt.vld  = r_inf.vld;
      w_ifid_nxt.pc   = r_inf.pc;
      w_ifid_nxt.inst = r_inf.vld ? i_rom_data : NOP_INST;
    end
  end

  // State registers with synchronous reset; the ROM enable comes up on the
  // first edge out of reset and stays up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc   <= RESET_PC;
      r_ce   <= 1'b0;
      r_inf  <= INF_RESET;
      r_ifid <= IFID_BUBBLE;
    end else begin
      r_pc   <= w_pc_nxt;
      r_ce   <= 1'b1;
      r_inf  <= w_inf_nxt;
      r_ifid <= w_ifid_nxt;
    end
  end

endmodule
